// File: rtl/dpc_lb_pkg.sv
// Shared limits and line-length clamping for the DPC line buffer.
package dpc_lb_pkg;
  localparam int MAX_WIDTH = 32;
  localparam int MAX_TAPS  = 8;

  function automatic logic len_bad(input int unsigned len, input int unsigned max_len);
    return (len == 0) || (len > max_len);
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return len_bad(len, max_len) ? max_len : len;
  endfunction
endpackage

// File: rtl/dpc_sdp_ram.sv
// Simple dual-port line RAM: one write port, one registered read port, read-first.
module dpc_sdp_ram #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/dpc_linebuf_taps.sv
// Cascaded line delays: emits the current pixel plus the same column from TAPS earlier lines.
module dpc_linebuf_taps
  import dpc_lb_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MAX_LEN = 1024,
  parameter int TAPS    = 2,
  parameter int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W:0]           cfg_len,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  output logic [ADDR_W-1:0]         out_col,
  output logic                      out_eol,
  output logic [(TAPS+1)*WIDTH-1:0] out_win,
  output logic [TAPS:0]             out_rows_valid,
  output logic                      cfg_err
);
  localparam int LW     = ADDR_W + 1;
  localparam int LC_W   = $clog2(TAPS + 1);
  localparam int STAGES = 2;

  if (WIDTH < 1 || WIDTH > MAX_WIDTH || TAPS < 1 || TAPS > MAX_TAPS) begin : g_param_chk
    $error("dpc_linebuf_taps: WIDTH or TAPS out of range");
  end

  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic [ADDR_W-1:0] col;
    logic [LC_W-1:0]   line;
    logic              eol;
  } s1_t;

  logic [LW-1:0]                len;
  logic [ADDR_W-1:0]            col;
  logic [LC_W-1:0]              line_cnt;
  logic                         cfg_err_q;
  logic [STAGES:1]              vld_pipe;
  s1_t                          s1;

  logic [TAPS-1:0][WIDTH-1:0]   ram_q, rd_eff, wr_d, byp_data;
  logic                         byp;
  logic                         wr_en;

  logic [ADDR_W-1:0]            col_q;
  logic                         eol_q;
  logic [TAPS:0][WIDTH-1:0]     win_q;
  logic [TAPS:0]                rv_q, rv_s1;

  logic [LW-1:0]                len_new, cur_len;
  logic                         cfg_bad, last;
  logic [ADDR_W-1:0]            cur_col;
  logic [LC_W-1:0]              cur_line;

  // An accepted sof re-seeds the pixel as column 0 of line 0 with a freshly sampled length.
  assign cfg_bad  = len_bad(32'(cfg_len), MAX_LEN);
  assign len_new  = LW'(clamp_len(32'(cfg_len), MAX_LEN));
  assign cur_len  = in_sof ? len_new : len;
  assign cur_col  = in_sof ? '0 : col;
  assign cur_line = in_sof ? '0 : line_cnt;
  assign last     = ({1'b0, cur_col} == (cur_len - LW'(1)));

  // With len==1 the next read hits the address being written this edge; forward the write data.
  assign rd_eff = byp ? byp_data : ram_q;
  assign wr_en  = vld_pipe[1] & ~reset;

  always_comb begin
    wr_d[0] = s1.data;
    for (int k = 1; k < TAPS; k++) wr_d[k] = rd_eff[k-1];
  end

  always_comb begin
    rv_s1 = '0;
    for (int k = 0; k <= TAPS; k++) rv_s1[k] = (32'(s1.line) >= k);
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    dpc_sdp_ram #(
      .WIDTH  (WIDTH),
      .DEPTH  (MAX_LEN),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (s1.col),
      .wr_data (wr_d[k]),
      .rd_en   (in_valid),
      .rd_addr (cur_col),
      .rd_data (ram_q[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len       <= len_new;
      cfg_err_q <= cfg_bad;
      col       <= '0;
      line_cnt  <= '0;
      vld_pipe  <= '0;
      s1        <= '0;
      byp       <= 1'b0;
      byp_data  <= '0;
      col_q     <= '0;
      eol_q     <= 1'b0;
      win_q     <= '0;
      rv_q      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      byp      <= in_valid & vld_pipe[1] & (cur_col == s1.col);
      byp_data <= wr_d;
      if (in_valid) begin
        if (in_sof) begin
          len       <= len_new;
          cfg_err_q <= cfg_err_q | cfg_bad;
        end
        col      <= last ? '0 : cur_col + ADDR_W'(1);
        line_cnt <= (last && cur_line != LC_W'(TAPS)) ? cur_line + LC_W'(1) : cur_line;
        s1       <= '{data: in_data, col: cur_col, line: cur_line, eol: last};
      end
      if (vld_pipe[1]) begin
        col_q <= s1.col;
        eol_q <= s1.eol;
        win_q <= {rd_eff, s1.data};
        rv_q  <= rv_s1;
      end else begin
        rv_q  <= '0;
      end
    end
  end

  assign out_valid      = vld_pipe[STAGES];
  assign out_col        = col_q;
  assign out_eol        = eol_q;
  assign out_win        = win_q;
  assign out_rows_valid = rv_q;
  assign cfg_err        = cfg_err_q;
endmodule

// File: tb/tb_dpc_linebuf_taps.sv
// Bench for dpc_linebuf_taps: table-driven fill/gap runs plus frame-coordinate model for corner cases.
module tb_dpc_linebuf_taps;
  localparam int W  = 16;
  localparam int ML = 1024;
  localparam int T  = 2;
  localparam int AW = 10;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [AW:0]           cfg_len = 11'd8;
  logic                  in_valid = 1'b0;
  logic                  in_sof = 1'b0;
  logic [W-1:0]          in_data = '0;
  logic                  out_valid;
  logic [AW-1:0]         out_col;
  logic                  out_eol;
  logic [(T+1)*W-1:0]    out_win;
  logic [T:0]            out_rows_valid;
  logic                  cfg_err;

  dpc_linebuf_taps #(.WIDTH(W), .MAX_LEN(ML), .TAPS(T)) dut (
    .clk(clk), .reset(reset), .cfg_len(cfg_len), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_col(out_col), .out_eol(out_eol),
    .out_win(out_win), .out_rows_valid(out_rows_valid), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]       col;
    logic                eol;
    logic [T:0]          rv;
    logic [T:0][W-1:0]   win;
  } exp_t;

  typedef struct {
    logic [W-1:0] d;
    exp_t         e;
  } tv_t;

  tv_t         tv [24];
  exp_t        q [$];
  int          checks = 0;
  int          errors = 0;
  bit [1:0]    vh = '0;
  int          mcol, mline, mlen;
  int unsigned fr [int];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int blen(input int c);
    return (c == 0 || c > ML) ? ML : c;
  endfunction

  task automatic check_out();
    exp_t e;
    chk("out_valid", 64'(out_valid), 64'(vh[1]));
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty actual=out_valid required=no_output at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("out_col", 64'(out_col), 64'(e.col));
        chk("out_eol", 64'(out_eol), 64'(e.eol));
        chk("rows_valid", 64'(out_rows_valid), 64'(e.rv));
        for (int k = 0; k <= T; k++)
          if (e.rv[k]) chk($sformatf("win_slice%0d", k), 64'(out_win[k*W +: W]), 64'(e.win[k]));
      end
    end else begin
      chk("rows_valid_idle", 64'(out_rows_valid), 64'd0);
    end
  endtask

  task automatic step(input bit v, input bit s, input logic [W-1:0] d, input bit rst, input exp_t e);
    @(negedge clk);
    check_out();
    reset    = rst;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    vh       = {vh[0], v};
    if (rst) begin
      vh = '0;
      q.delete();
    end else if (v) begin
      q.push_back(e);
    end
  endtask

  // Reference: pixel store addressed by (line within frame, column).
  task automatic model(input logic [W-1:0] d, input bit s, output exp_t e);
    if (s) begin
      fr.delete();
      mline = 0;
      mcol  = 0;
      mlen  = blen(int'(cfg_len));
    end
    e        = '0;
    e.col    = AW'(mcol);
    e.eol    = (mcol == mlen - 1);
    e.win[0] = d;
    for (int k = 0; k <= T; k++)
      if (mline >= k) begin
        e.rv[k] = 1'b1;
        if (k > 0) e.win[k] = W'(fr[(mline - k) * 2048 + mcol]);
      end
    fr[mline * 2048 + mcol] = 32'(d);
    if (mcol == mlen - 1) begin
      mcol = 0;
      mline++;
    end else begin
      mcol++;
    end
  endtask

  task automatic model_reset();
    fr.delete();
    mline = 0;
    mcol  = 0;
    mlen  = blen(int'(cfg_len));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset(input int len);
    cfg_len = (AW+1)'(len);
    step(1'b0, 1'b0, '0, 1'b1, '0);
    model_reset();
    step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic px(input logic [W-1:0] d, input bit s);
    exp_t e;
    model(d, s, e);
    step(1'b1, s, d, 1'b0, e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Gap-free fill of an 8-pixel line: slice k is the pixel 8*k earlier.
    for (int i = 0; i < 24; i++) begin
      tv[i].d        = W'(i);
      tv[i].e        = '0;
      tv[i].e.col    = AW'(i % 8);
      tv[i].e.eol    = (i % 8 == 7);
      tv[i].e.rv     = (i < 8) ? 3'b001 : (i < 16) ? 3'b011 : 3'b111;
      tv[i].e.win[0] = W'(i);
      if (i >= 8)  tv[i].e.win[1] = W'(i - 8);
      if (i >= 16) tv[i].e.win[2] = W'(i - 16);
    end

    do_reset(8);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_col", 64'(out_col), 64'd0);
    chk("rst_out_eol", 64'(out_eol), 64'd0);
    chk("rst_out_win", 64'(out_win), 64'd0);
    chk("rst_rows_valid", 64'(out_rows_valid), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);

    for (int i = 0; i < 24; i++) step(1'b1, 1'b0, tv[i].d, 1'b0, tv[i].e);
    idle(3);

    // Same vectors with random idle cycles must produce identical windows.
    do_reset(8);
    for (int i = 0; i < 24; i++) begin
      while ($urandom_range(0, 2) == 0) idle(1);
      step(1'b1, 1'b0, tv[i].d, 1'b0, tv[i].e);
    end
    idle(3);

    // Frame restart at column 5 of line 2, then one more full line.
    do_reset(8);
    for (int i = 0; i < 21; i++) px(W'(100 + i), 1'b0);
    px(W'(200), 1'b1);
    for (int i = 0; i < 9; i++) px(W'(201 + i), 1'b0);
    idle(3);

    // Reset pulse in the middle of line 1 drops in-flight pixels.
    do_reset(8);
    for (int i = 0; i < 10; i++) px(W'(300 + i), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, '0);
    model_reset();
    for (int i = 0; i < 5; i++) px(W'(400 + i), 1'b0);
    idle(3);

    // Illegal length clamps to MAX_LEN.
    do_reset(0);
    chk("cfg_err_len0", 64'(cfg_err), 64'd1);
    for (int i = 0; i < ML + 2; i++) px(W'(i), 1'b0);
    idle(3);
    chk("cfg_err_sticky", 64'(cfg_err), 64'd1);

    // Length 1: every pixel is a new line, exercising the same-address bypass.
    do_reset(1);
    chk("cfg_err_len1", 64'(cfg_err), 64'd0);
    for (int i = 0; i < 8; i++) px(W'(500 + i), 1'b0);
    idle(1);
    px(W'(600), 1'b0);
    px(W'(601), 1'b0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
